// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//
// Purpose
//   Read-side adapter for shift_register_fifo. It pops the FIFO only when the
//   FIFO reports data and the local buffer has room, so a pop while empty
//   cannot be issued. Popped words are re-presented downstream as a
//   registered valid/ready stream through a 2-entry skid buffer, and every
//   word accepted downstream is counted.
//
// Parameters
//   WIDTH      data width, equal to the FIFO word width
//   CNT_WIDTH  width of the accepted-word counter (wraps modulo 2^CNT_WIDTH)
//
// Ports
//   clk         in   1          single clock, all state on the rising edge
//   rst         in   1          synchronous, active-high reset
//   fifo_empty  in   1          FIFO empty flag
//   fifo_data   in   WIDTH      FIFO head word, meaningful when !fifo_empty
//   fifo_pop    out  1          pop strobe to the FIFO
//   out_valid   out  1          output word valid (registered)
//   out_ready   in   1          downstream accept
//   out_data    out  WIDTH      output word (registered, head buffer entry)
//   flush       in   1          synchronous discard of buffered words
//   xfer_count  out  CNT_WIDTH  number of words accepted downstream
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_pop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    // Buffer occupancy doubles as the FSM state.
    typedef enum logic [1:0] {
        ZERO = 2'd0,
        ONE  = 2'd1,
        TWO  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [WIDTH-1:0]     e0_r;
    logic [WIDTH-1:0]     e0_nxt_s;
    logic [WIDTH-1:0]     e1_r;
    logic [WIDTH-1:0]     e1_nxt_s;
    logic                 valid_r;
    logic [CNT_WIDTH-1:0] xfer_r;
    logic                 pop_s;
    logic                 deq_s;

    // Pop decision depends only on reset, flush, the FIFO flag and the local
    // occupancy; out_ready is deliberately kept out of this path so the pop
    // strobe never waits on the downstream consumer combinationally.
    always_comb begin
        pop_s = 1'b0;
        if (!rst && !flush && !fifo_empty && (state_r != TWO)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // A word leaves the buffer when it is presented and accepted.
    always_comb begin
        deq_s = valid_r & out_ready;
    end

    // Next-state and buffer-entry update for every (pop, deq) combination.
    always_comb begin
        state_nxt_s = state_r;
        e0_nxt_s    = e0_r;
        e1_nxt_s    = e1_r;

        case (state_r)
            ZERO: begin
                // Nothing is presented, so only a pop can happen here.
                if (pop_s) begin
                    state_nxt_s = ONE;
                    e0_nxt_s    = fifo_data;
                end else begin
                    state_nxt_s = ZERO;
                end
            end
            ONE: begin
                if (pop_s && deq_s) begin
                    // Head leaves and the freshly popped word replaces it.
                    state_nxt_s = ONE;
                    e0_nxt_s    = fifo_data;
                end else if (pop_s && !deq_s) begin
                    // Head stalls; the popped word parks behind it.
                    state_nxt_s = TWO;
                    e1_nxt_s    = fifo_data;
                end else if (!pop_s && deq_s) begin
                    state_nxt_s = ZERO;
                end else begin
                    state_nxt_s = ONE;
                end
            end
            TWO: begin
                // Full, so no pop; a deq promotes the parked word to head.
                if (deq_s) begin
                    state_nxt_s = ONE;
                    e0_nxt_s    = e1_r;
                end else begin
                    state_nxt_s = TWO;
                end
            end
            default: begin
                state_nxt_s = ZERO;
            end
        endcase

        // Flush drops the buffered words but leaves the head data register
        // alone, so out_data simply holds while invalid.
        if (flush) begin
            state_nxt_s = ZERO;
            e0_nxt_s    = e0_r;
            e1_nxt_s    = e1_r;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State, buffer entries and registered valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ZERO;
            e0_r    <= {WIDTH{1'b0}};
            e1_r    <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            e0_r    <= e0_nxt_s;
            e1_r    <= e1_nxt_s;
            valid_r <= (state_nxt_s != ZERO);
        end
    end

    // Accepted-word counter; a deq in a flush cycle still counts because the
    // consumer took the word. Wraps naturally from all-ones to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_r <= {CNT_WIDTH{1'b0}};
        end else if (deq_s) begin
            xfer_r <= xfer_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            xfer_r <= xfer_r;
        end
    end

    assign fifo_pop   = pop_s;
    assign out_valid  = valid_r;
    assign out_data   = e0_r;
    assign xfer_count = xfer_r;

endmodule
